// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable 32-entry instruction memory, program counter,
// one-bubble branch redirect, downstream stall and HALT-word freeze.
module instr_fetch_unit #(
   parameter int                 ADDR_W    = 5,
   parameter int                 DATA_W    = 32,
   parameter int                 DEPTH     = 32,
   parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              halted
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_LOAD  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   npc_q, npc_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                halted_q, halted_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   fetch_word;

   // Memory has no reset; contents survive rst and are only changed by loads.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_q[load_addr] <= load_data;
      end
   end

   assign fetch_word = mem_q[npc_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_RUN;
         npc_q    <= '0;
         pc_q     <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         npc_q    <= npc_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      npc_d    = npc_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      halted_d = halted_q;

      if (load_en) begin
         state_d  = S_LOAD;
         npc_d    = '0;
         pc_d     = '0;
         instr_d  = '0;
         valid_d  = 1'b0;
         halted_d = 1'b0;
      end else begin
         unique case (state_q)
            S_RUN, S_FLUSH: begin
               // A redirect wins over stall so it can never be dropped.
               if (branch_taken) begin
                  state_d = S_FLUSH;
                  npc_d   = branch_target;
                  instr_d = '0;
                  valid_d = 1'b0;
               end else if (!stall) begin
                  instr_d = fetch_word;
                  pc_d    = npc_q;
                  valid_d = 1'b1;
                  if (fetch_word == HALT_WORD) begin
                     state_d  = S_HALT;
                     halted_d = 1'b1;
                  end else begin
                     state_d = S_RUN;
                     npc_d   = npc_q + ADDR_W'(1);
                  end
               end
            end
            S_LOAD: begin
               state_d = S_RUN;
               npc_d   = '0;
            end
            S_HALT: begin
               valid_d = 1'b0;
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each task drives one scenario and checks
// (pc, instr, instr_valid, halted) one cycle at a time against hand-computed values.
module tb_instr_fetch_unit;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              halted;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_unit #(.ADDR_W(5), .DATA_W(32), .DEPTH(32), .HALT_WORD(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .instr(instr), .instr_valid(instr_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [4:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
   endtask

   task automatic release_load();
      load_en = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      tick();
      tick();
      n_checks++;
      if ({pc, instr, instr_valid, halted} !== {5'd0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: pc=%0d instr=%h valid=%b halted=%b, want 0/0/0/0",
                  pc, instr, instr_valid, halted);
      end
      rst = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 32; i++) load_word(5'(i), 32'hA000_0000 + 32'(i));
      n_checks++;
      if ({pc, instr, instr_valid, halted} !== {5'd0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL fill_outputs: pc=%0d instr=%h valid=%b halted=%b, want 0/0/0/0",
                  pc, instr, instr_valid, halted);
      end
   endtask

   task automatic test_halt_seq();
      logic [31:0] exp_i [4];
      exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33; exp_i[3] = HALT;
      for (int i = 0; i < 4; i++) load_word(5'(i), exp_i[i]);
      release_load();
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({pc, instr, instr_valid, halted} !== {5'(i), exp_i[i], 1'b1, (i == 3)}) begin
            n_fail++;
            $display("FAIL halt_seq[%0d]: pc=%0d instr=%h valid=%b halted=%b, want %0d/%h/1/%b",
                     i, pc, instr, instr_valid, halted, i, exp_i[i], (i == 3));
         end
      end
      for (int i = 0; i < 10; i++) begin
         branch_taken  = (i == 2) || (i == 3);
         branch_target = 5'd7;
         stall         = (i == 5);
         tick();
         n_checks++;
         if ({pc, instr, instr_valid, halted} !== {5'd3, HALT, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_hold[%0d]: pc=%0d instr=%h valid=%b halted=%b, want 3/ffffffff/0/1",
                     i, pc, instr, instr_valid, halted);
         end
      end
      branch_taken = 1'b0; stall = 1'b0;
   endtask

   task automatic test_stall();
      load_word(5'd3, 32'h44);
      n_checks++;
      if ({pc, instr, instr_valid, halted} !== {5'd0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL load_exits_halt: pc=%0d instr=%h valid=%b halted=%b, want 0/0/0/0",
                  pc, instr, instr_valid, halted);
      end
      release_load();
      tick();
      tick();
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd1, 32'h22, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_pre: pc=%0d instr=%h valid=%b, want 1/22/1", pc, instr, instr_valid);
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({pc, instr, instr_valid} !== {5'd1, 32'h22, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: pc=%0d instr=%h valid=%b, want 1/22/1",
                     i, pc, instr, instr_valid);
         end
      end
      stall = 1'b0;
      tick();
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd2, 32'h33, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_release: pc=%0d instr=%h valid=%b, want 2/33/1", pc, instr, instr_valid);
      end
   endtask

   task automatic test_branch();
      branch_taken = 1'b1; branch_target = 5'd9;
      tick();
      branch_taken = 1'b0;
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd2, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL branch_bubble: pc=%0d instr=%h valid=%b, want 2/0/0", pc, instr, instr_valid);
      end
      tick();
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd9, 32'hA000_0009, 1'b1}) begin
         n_fail++;
         $display("FAIL branch_target: pc=%0d instr=%h valid=%b, want 9/a0000009/1", pc, instr, instr_valid);
      end
   endtask

   task automatic test_branch_stall();
      branch_taken = 1'b1; branch_target = 5'd5; stall = 1'b1;
      tick();
      branch_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({pc, instr, instr_valid} !== {5'd9, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL branch_stall_bubble[%0d]: pc=%0d instr=%h valid=%b, want 9/0/0",
                     i, pc, instr, instr_valid);
         end
         if (i < 2) tick();
      end
      stall = 1'b0;
      tick();
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd5, 32'hA000_0005, 1'b1}) begin
         n_fail++;
         $display("FAIL branch_stall_release: pc=%0d instr=%h valid=%b, want 5/a0000005/1",
                  pc, instr, instr_valid);
      end
   endtask

   task automatic test_back_to_back();
      branch_taken = 1'b1; branch_target = 5'd12;
      tick();
      branch_target = 5'd20;
      tick();
      branch_taken = 1'b0;
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd5, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_bubble: pc=%0d instr=%h valid=%b, want 5/0/0", pc, instr, instr_valid);
      end
      tick();
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd20, 32'hA000_0014, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_target: pc=%0d instr=%h valid=%b, want 20/a0000014/1", pc, instr, instr_valid);
      end
   endtask

   task automatic test_wrap();
      logic [4:0]  exp_pc [4];
      logic [31:0] exp_i  [4];
      exp_pc[0] = 5'd30; exp_pc[1] = 5'd31; exp_pc[2] = 5'd0; exp_pc[3] = 5'd1;
      exp_i[0] = 32'hAAAA_0030; exp_i[1] = 32'hBBBB_0031; exp_i[2] = 32'hCCCC_0000; exp_i[3] = 32'h22;
      load_word(5'd30, 32'hAAAA_0030);
      load_word(5'd31, 32'hBBBB_0031);
      load_word(5'd0,  32'hCCCC_0000);
      release_load();
      branch_taken = 1'b1; branch_target = 5'd30;
      tick();
      branch_taken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({pc, instr, instr_valid} !== {exp_pc[i], exp_i[i], 1'b1}) begin
            n_fail++;
            $display("FAIL wrap[%0d]: pc=%0d instr=%h valid=%b, want %0d/%h/1",
                     i, pc, instr, instr_valid, exp_pc[i], exp_i[i]);
         end
      end
   endtask

   task automatic test_reset_flush();
      branch_taken = 1'b1; branch_target = 5'd4;
      tick();
      rst = 1'b1; stall = 1'b1;
      tick();
      n_checks++;
      if ({pc, instr, instr_valid, halted} !== {5'd0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_flush: pc=%0d instr=%h valid=%b halted=%b, want 0/0/0/0",
                  pc, instr, instr_valid, halted);
      end
      rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
      tick();
      n_checks++;
      if ({pc, instr, instr_valid} !== {5'd0, 32'hCCCC_0000, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_flush_resume: pc=%0d instr=%h valid=%b, want 0/cccc0000/1",
                  pc, instr, instr_valid);
      end
   endtask

   task automatic test_reset_halt();
      load_word(5'd2, HALT);
      release_load();
      tick(); tick(); tick();
      n_checks++;
      if ({pc, instr, instr_valid, halted} !== {5'd2, HALT, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL halt_mid: pc=%0d instr=%h valid=%b halted=%b, want 2/ffffffff/1/1",
                  pc, instr, instr_valid, halted);
      end
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({pc, instr, instr_valid, halted} !== {5'd0, 32'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_halt: pc=%0d instr=%h valid=%b halted=%b, want 0/0/0/0",
                  pc, instr, instr_valid, halted);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if ({pc, instr, instr_valid, halted} !== {5'd0, 32'hCCCC_0000, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_halt_resume: pc=%0d instr=%h valid=%b halted=%b, want 0/cccc0000/1/0",
                  pc, instr, instr_valid, halted);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_halt_seq();
      test_stall();
      test_branch();
      test_branch_stall();
      test_back_to_back();
      test_wrap();
      test_reset_flush();
      test_reset_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
